// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the writeback-side register file.
// Address/data widths, r0 index and reset polarity.
package cpu_defs;

    localparam int NREG   = 32;
    localparam int AW     = $clog2(NREG);
    localparam int DW     = 32;
    localparam int PEND_W = 2;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] data_t;
    typedef logic [PEND_W-1:0] pend_t;

    localparam reg_addr_t ZERO_REG = 5'd0;
    localparam logic      RST_ACT  = 1'b1;
    localparam pend_t     PEND_MAX = '1;

endpackage

// File: rtl/wb_regfile_if.sv
// Bus between pipeline (master) and register file (slave):
// writeback port, two read ports, issue port, stall and error.
interface wb_regfile_if;
    import cpu_defs::*;

    logic      wb_wd;
    reg_addr_t wb_wreg;
    data_t     wb_wdata;
    logic      re1;
    reg_addr_t raddr1;
    data_t     rdata1;
    logic      re2;
    reg_addr_t raddr2;
    data_t     rdata2;
    logic      iss_wd;
    reg_addr_t iss_wreg;
    logic      stall_req;
    logic      sb_err;

    modport master (
        output wb_wd, wb_wreg, wb_wdata,
        output re1, raddr1, re2, raddr2,
        output iss_wd, iss_wreg,
        input  rdata1, rdata2, stall_req, sb_err
    );

    modport slave (
        input  wb_wd, wb_wreg, wb_wdata,
        input  re1, raddr1, re2, raddr2,
        input  iss_wd, iss_wreg,
        output rdata1, rdata2, stall_req, sb_err
    );

endinterface

// File: rtl/wb_regfile_scoreboard.sv
// Per-register pending-write counters and read hazard detection.
// Counters saturate; any over/underflow latches a sticky error.
module wb_scoreboard import cpu_defs::*; (
    input  logic      clk,
    input  logic      rst,
    input  logic      iss_wd,
    input  reg_addr_t iss_wreg,
    input  logic      wb_wd,
    input  reg_addr_t wb_wreg,
    input  logic      re1,
    input  reg_addr_t raddr1,
    input  logic      re2,
    input  reg_addr_t raddr2,
    output logic      stall_req,
    output logic      sb_err
);

    pend_t cnt_q [NREG];
    pend_t cnt_d [NREG];
    logic  err_q, err_d;
    logic  inc, dec;
    logic  haz1, haz2;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        inc   = 1'b0;
        dec   = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            inc = iss_wd && (iss_wreg == AW'(r));
            dec = wb_wd && (wb_wreg == AW'(r));
            if (inc && !dec) begin
                if (cnt_q[r] == PEND_MAX) err_d = 1'b1;
                else cnt_d[r] = cnt_q[r] + PEND_W'(1);
            end else if (dec && !inc) begin
                if (cnt_q[r] == '0) err_d = 1'b1;
                else cnt_d[r] = cnt_q[r] - PEND_W'(1);
            end
        end
    end

    // A last outstanding write landing this cycle is bypassed, not stalled.
    always_comb begin
        haz1 = re1 && (raddr1 != ZERO_REG) && (cnt_q[raddr1] != '0)
            && !(wb_wd && (wb_wreg == raddr1)
                 && (cnt_q[raddr1] == PEND_W'(1)));
        haz2 = re2 && (raddr2 != ZERO_REG) && (cnt_q[raddr2] != '0)
            && !(wb_wd && (wb_wreg == raddr2)
                 && (cnt_q[raddr2] == PEND_W'(1)));
    end

    assign stall_req = haz1 | haz2;
    assign sb_err    = err_q;

    always_ff @(posedge clk) begin
        if (rst == RST_ACT) begin
            cnt_q <= '{default: '0};
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// 32x32 architectural register file fed by writeback,
// with same-cycle bypass to both decode read ports.
module wb_regfile import cpu_defs::*; (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    data_t regs_q [NREG];
    data_t regs_d [NREG];
    logic  stall;
    logic  err;

    function automatic data_t rd_sel(
        input logic      re,
        input reg_addr_t a,
        input logic      bwd,
        input reg_addr_t bwr,
        input data_t     bwdat,
        input data_t     arch
    );
        if (!re || a == ZERO_REG) return '0;
        else if (bwd && bwr == a) return bwdat;
        else return arch;
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (bus.wb_wd && bus.wb_wreg != ZERO_REG)
            regs_d[bus.wb_wreg] = bus.wb_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ACT) regs_q <= '{default: '0};
        else regs_q <= regs_d;
    end

    assign bus.rdata1 = rd_sel(bus.re1, bus.raddr1, bus.wb_wd,
                               bus.wb_wreg, bus.wb_wdata,
                               regs_q[bus.raddr1]);
    assign bus.rdata2 = rd_sel(bus.re2, bus.raddr2, bus.wb_wd,
                               bus.wb_wreg, bus.wb_wdata,
                               regs_q[bus.raddr2]);

    wb_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .iss_wd    (bus.iss_wd),
        .iss_wreg  (bus.iss_wreg),
        .wb_wd     (bus.wb_wd),
        .wb_wreg   (bus.wb_wreg),
        .re1       (bus.re1),
        .raddr1    (bus.raddr1),
        .re2       (bus.re2),
        .raddr2    (bus.raddr2),
        .stall_req (stall),
        .sb_err    (err)
    );

    assign bus.stall_req = stall;
    assign bus.sb_err    = err;

endmodule
